// File: rtl/fixed_mult_seq_if.sv
// Operand/result handshake bundle for the sequential sign-magnitude multiplier.
// The master is the producer/consumer side; the slave is the multiplier itself.
interface fixed_mult_seq_if #(
   parameter int W = 17
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] ab;
   logic         clip_int;
   logic         clip_frac;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, ab, clip_int, clip_frac
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, ab, clip_int, clip_frac
   );
endinterface

// File: rtl/fixed_mult_seq.sv
// Shift-add sign-magnitude fixed-point multiplier, one multiplier bit per cycle,
// with optional round-half-up and registered saturation / precision-loss flags.
module fixed_mult_seq #(
   parameter int INT_W  = 8,
   parameter int FRAC_W = 8,
   parameter int ROUND  = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   fixed_mult_seq_if.slave  bus
);
   localparam int M   = INT_W + FRAC_W;
   localparam int W   = M + 1;
   localparam int CW  = $clog2(M + 1);
   localparam int P_W = 2 * M;
   localparam int Q_W = M + INT_W;
   localparam int S_W = M + 1 + INT_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      FIN  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t          state_reg,     state_next;
   logic [M-1:0]    mcand_reg,     mcand_next;
   logic [M-1:0]    mplier_reg,    mplier_next;
   logic            sign_reg,      sign_next;
   logic [P_W-1:0]  acc_reg,       acc_next;
   logic [CW-1:0]   cnt_reg,       cnt_next;
   logic [W-1:0]    ab_reg,        ab_next;
   logic            clip_int_reg,  clip_int_next;
   logic            clip_frac_reg, clip_frac_next;

   logic [P_W-1:0]  addend;
   logic [Q_W-1:0]  q;
   logic            rnd;
   logic [S_W-1:0]  m_sum;
   logic            sat;
   logic [M-1:0]    mag;

   assign addend = {{M{1'b0}}, mcand_reg} << cnt_reg;

   // Result path works on the wide sum so a rounding carry out of q cannot wrap.
   assign q     = acc_reg[P_W-1:FRAC_W];
   assign rnd   = (ROUND != 0) ? acc_reg[FRAC_W-1] : 1'b0;
   assign m_sum = {1'b0, q} + {{(S_W-1){1'b0}}, rnd};
   assign sat   = |m_sum[S_W-1:M];
   assign mag   = sat ? {M{1'b1}} : m_sum[M-1:0];

   always_comb begin
      state_next     = state_reg;
      mcand_next     = mcand_reg;
      mplier_next    = mplier_reg;
      sign_next      = sign_reg;
      acc_next       = acc_reg;
      cnt_next       = cnt_reg;
      ab_next        = ab_reg;
      clip_int_next  = clip_int_reg;
      clip_frac_next = clip_frac_reg;

      case (state_reg)
         IDLE: begin
            if (bus.in_valid) begin
               mcand_next  = bus.a[M-1:0];
               mplier_next = bus.b[M-1:0];
               sign_next   = bus.a[W-1] ^ bus.b[W-1];
               acc_next    = '0;
               cnt_next    = '0;
               state_next  = BUSY;
            end
         end
         BUSY: begin
            if (mplier_reg[0]) begin
               acc_next = acc_reg + addend;
            end
            mplier_next = mplier_reg >> 1;
            cnt_next    = cnt_reg + 1'b1;
            if (cnt_reg == CW'(M - 1)) begin
               state_next = FIN;
            end
         end
         FIN: begin
            // A zero magnitude always leaves with a positive sign.
            ab_next        = {sign_reg & (|mag), mag};
            clip_int_next  = sat;
            clip_frac_next = |acc_reg[FRAC_W-1:0];
            state_next     = DONE;
         end
         DONE: begin
            if (bus.out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         mcand_reg     <= '0;
         mplier_reg    <= '0;
         sign_reg      <= 1'b0;
         acc_reg       <= '0;
         cnt_reg       <= '0;
         ab_reg        <= '0;
         clip_int_reg  <= 1'b0;
         clip_frac_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         mcand_reg     <= mcand_next;
         mplier_reg    <= mplier_next;
         sign_reg      <= sign_next;
         acc_reg       <= acc_next;
         cnt_reg       <= cnt_next;
         ab_reg        <= ab_next;
         clip_int_reg  <= clip_int_next;
         clip_frac_reg <= clip_frac_next;
      end
   end

   assign bus.in_ready  = (state_reg == IDLE);
   assign bus.out_valid = (state_reg == DONE);
   assign bus.ab        = ab_reg;
   assign bus.clip_int  = clip_int_reg;
   assign bus.clip_frac = clip_frac_reg;
endmodule

// File: tb/tb_fixed_mult_seq.sv
// Directed bench for fixed_mult_seq: a ROUND=1 and a ROUND=0 instance share
// the same stimulus so every vector checks both rounding modes.
module tb_fixed_mult_seq;
   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_fail;

   fixed_mult_seq_if #(.W(17)) bus ();
   fixed_mult_seq_if #(.W(17)) bus0 ();

   assign bus0.in_valid  = bus.in_valid;
   assign bus0.a         = bus.a;
   assign bus0.b         = bus.b;
   assign bus0.out_ready = bus.out_ready;

   fixed_mult_seq #(.INT_W(8), .FRAC_W(8), .ROUND(1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   fixed_mult_seq #(.INT_W(8), .FRAC_W(8), .ROUND(0)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_out(input string tag);
      int n;
      n = 0;
      while (!bus.out_valid && n < 100) begin
         tick();
         n++;
      end
      check({tag, ".latency"}, 32'(n), 32'd17);
   endtask

   task automatic accept(input string tag, input logic [16:0] ai, input logic [16:0] bi);
      int n;
      n = 0;
      while (!bus.in_ready && n < 50) begin
         tick();
         n++;
      end
      check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
      bus.a        = ai;
      bus.b        = bi;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      bus.a        = 17'h1FFFF;
      bus.b        = 17'h1FFFF;
      check({tag, ".busy"}, 32'(bus.in_ready), 32'd0);
   endtask

   task automatic handshake(input string tag);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check({tag, ".hs_ov"}, 32'(bus.out_valid), 32'd0);
      check({tag, ".hs_ir"}, 32'(bus.in_ready), 32'd1);
   endtask

   task automatic run_op(input string tag, input logic [16:0] ai, input logic [16:0] bi,
                         input logic [16:0] exp_ab, input logic [16:0] exp_ab0,
                         input logic exp_ci, input logic exp_cf);
      accept(tag, ai, bi);
      wait_out(tag);
      check({tag, ".ab"},        32'(bus.ab),         32'(exp_ab));
      check({tag, ".clip_int"},  32'(bus.clip_int),   32'(exp_ci));
      check({tag, ".clip_frac"}, 32'(bus.clip_frac),  32'(exp_cf));
      check({tag, ".ab_r0"},     32'(bus0.ab),        32'(exp_ab0));
      check({tag, ".cf_r0"},     32'(bus0.clip_frac), 32'(exp_cf));
      $display("op %-10s a=%05h b=%05h ab=%05h ci=%0b cf=%0b ab_r0=%05h", tag, ai, bi,
               bus.ab, bus.clip_int, bus.clip_frac, bus0.ab);
      handshake(tag);
   endtask

   initial begin
      n_cmp         = 0;
      n_fail        = 0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      rst_n         = 1'b1;
      #2;
      rst_n = 1'b0;
      tick();
      tick();
      check("rst.in_ready",  32'(bus.in_ready),  32'd1);
      check("rst.out_valid", 32'(bus.out_valid), 32'd0);
      check("rst.ab",        32'(bus.ab),        32'd0);
      rst_n = 1'b1;
      tick();

      //       tag          a          b          ab(R=1)    ab(R=0)    ci    cf
      run_op("basic",     17'h00200, 17'h00200, 17'h00400, 17'h00400, 1'b0, 1'b0);
      run_op("neg_pos",   17'h10200, 17'h00200, 17'h10400, 17'h10400, 1'b0, 1'b0);
      run_op("neg_neg",   17'h10200, 17'h10200, 17'h00400, 17'h00400, 1'b0, 1'b0);
      run_op("half",      17'h00080, 17'h00080, 17'h00040, 17'h00040, 1'b0, 1'b0);
      run_op("sat_pos",   17'h01000, 17'h01000, 17'h0FFFF, 17'h0FFFF, 1'b1, 1'b0);
      run_op("sat_neg",   17'h11000, 17'h01000, 17'h1FFFF, 17'h1FFFF, 1'b1, 1'b0);
      run_op("round_nz",  17'h10001, 17'h00080, 17'h10001, 17'h00000, 1'b0, 1'b1);
      run_op("one5sq",    17'h00180, 17'h00180, 17'h00240, 17'h00240, 1'b0, 1'b0);
      run_op("round_up",  17'h00181, 17'h00003, 17'h00005, 17'h00004, 1'b0, 1'b1);
      run_op("negzero",   17'h10000, 17'h00200, 17'h00000, 17'h00000, 1'b0, 1'b0);

      // Consumer stall: results held, in_valid pulses ignored.
      accept("stall", 17'h00300, 17'h10180);
      wait_out("stall");
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = 1'b1;
         bus.a        = 17'h00001;
         bus.b        = 17'h00001;
         tick();
         check("stall.ab", 32'(bus.ab),        32'h10480);
         check("stall.ov", 32'(bus.out_valid), 32'd1);
         check("stall.ir", 32'(bus.in_ready),  32'd0);
         check("stall.cf", 32'(bus.clip_frac), 32'd0);
      end
      bus.in_valid = 1'b0;
      $display("op %-10s a=00300 b=10180 ab=%05h held 5 cycles", "stall", bus.ab);
      handshake("stall");

      // Leave both flags set so the asynchronous reset has something to clear.
      run_op("sat_frac",  17'h01001, 17'h01001, 17'h0FFFF, 17'h0FFFF, 1'b1, 1'b1);

      accept("abort", 17'h00700, 17'h00500);
      for (int i = 0; i < 4; i++) tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("abort.ab",        32'(bus.ab),        32'd0);
      check("abort.clip_int",  32'(bus.clip_int),  32'd0);
      check("abort.clip_frac", 32'(bus.clip_frac), 32'd0);
      check("abort.in_ready",  32'(bus.in_ready),  32'd1);
      check("abort.out_valid", 32'(bus.out_valid), 32'd0);
      check("abort.ab_r0",     32'(bus0.ab),       32'd0);
      $display("op %-10s reset mid-BUSY ab=%05h in_ready=%0b", "abort", bus.ab, bus.in_ready);
      tick();
      rst_n = 1'b1;
      tick();

      run_op("post_rst",  17'h00200, 17'h00300, 17'h00600, 17'h00600, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
